generador_vectores: RTL and testbench

//  Upstream stimulus/capture stage for the 3-input combinational block funcion_logica.

---
 rtl/gen_vec_pkg.sv | 17 +
 rtl/generador_vectores_contador_ret.sv | 34 +++
 rtl/generador_vectores.sv | 103 ++++++++++
 tb/tb_generador_vectores.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gen_vec_pkg.sv
// Shared encodings and helpers for generador_vectores.
// State codes and hold-counter width function.
package gen_vec_pkg;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_APLICA = 1'b1;

  typedef logic estado_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/generador_vectores_contador_ret.sv
// Hold counter: counts 0..HOLD_CYCLES-1 while enabled.
// ultimo flags the final hold cycle of a vector.
module contador_ret
  import gen_vec_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic ultimo
);

  localparam int CW = clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] MAXC = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] count;

  assign ultimo = (count == MAXC);

  // wrap at the last hold cycle, clear when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (ultimo) count <= '0;
      else        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/generador_vectores.sv
// Exhaustive input sweep with truth-table capture and check.
// Optional first-failure diagnostics: GEN_VEC_DIAG_EN.
module generador_vectores
  import gen_vec_pkg::*;
#(
  parameter int N_IN        = 3,
  parameter int HOLD_CYCLES = 10,
  localparam int N_VEC      = 2 ** N_IN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             f,
  input  logic [N_VEC-1:0] esperada,
  output logic [N_IN-1:0]  vec,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] tabla,
  output logic             error
`ifdef GEN_VEC_DIAG_EN
  ,
  output logic [N_IN-1:0]  primer_fallo,
  output logic             fallo_valido
`endif
);

  localparam logic [N_IN-1:0] VEC_ULT = N_IN'(N_VEC - 1);

  estado_t          state;
  logic             ultimo;
  logic [N_VEC-1:0] tabla_nueva;

  contador_ret #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_IDLE),
    .en    (state == ST_APLICA),
    .ultimo(ultimo)
  );

  // table with the current sample merged in
  always_comb begin
    tabla_nueva      = tabla;
    tabla_nueva[vec] = f;
  end

  // sweep FSM, capture and final compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      vec   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      tabla <= '0;
      error <= 1'b0;
`ifdef GEN_VEC_DIAG_EN
      primer_fallo <= '0;
      fallo_valido <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_APLICA;
            busy  <= 1'b1;
            vec   <= '0;
            tabla <= '0;
            error <= 1'b0;
`ifdef GEN_VEC_DIAG_EN
            primer_fallo <= '0;
            fallo_valido <= 1'b0;
`endif
          end
        end
        ST_APLICA: begin
          if (ultimo) begin
            tabla <= tabla_nueva;
`ifdef GEN_VEC_DIAG_EN
            if ((f != esperada[vec]) && !fallo_valido) begin
              primer_fallo <= vec;
              fallo_valido <= 1'b1;
            end
`endif
            if (vec == VEC_ULT) begin
              state <= ST_IDLE;
              vec   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              error <= (tabla_nueva != esperada);
            end else begin
              vec <= vec + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_generador_vectores.sv
// Self-checking bench for generador_vectores.
// Scoreboard of expected tabla/error per sweep.
module tb_generador_vectores;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       f;
  logic [7:0] esperada;
  logic [2:0] vec;
  logic       busy;
  logic       done;
  logic [7:0] tabla;
  logic       error;
`ifdef GEN_VEC_DIAG_EN
  logic [2:0] primer_fallo;
  logic       fallo_valido;
`endif

  logic       start1;
  logic       f1;
  logic [2:0] vec1;
  logic       busy1;
  logic       done1;
  logic [7:0] tabla1;
  logic       error1;
`ifdef GEN_VEC_DIAG_EN
  logic [2:0] primer_fallo1;
  logic       fallo_valido1;
`endif

  logic [7:0] fmask;
  logic [8:0] sb_q[$];
  int checks;
  int failures;

  function automatic logic maj(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  function automatic logic [7:0] golden(input logic [7:0] m);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[i] = maj(3'(i)) ^ m[i];
    return t;
  endfunction

  assign f  = maj(vec) ^ fmask[vec];
  assign f1 = maj(vec1);

  generador_vectores #(.N_IN(3), .HOLD_CYCLES(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .f       (f),
    .esperada(esperada),
    .vec     (vec),
    .busy    (busy),
    .done    (done),
    .tabla   (tabla),
    .error   (error)
`ifdef GEN_VEC_DIAG_EN
    ,
    .primer_fallo(primer_fallo),
    .fallo_valido(fallo_valido)
`endif
  );

  generador_vectores #(.N_IN(3), .HOLD_CYCLES(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start1),
    .f       (f1),
    .esperada(8'hE8),
    .vec     (vec1),
    .busy    (busy1),
    .done    (done1),
    .tabla   (tabla1),
    .error   (error1)
`ifdef GEN_VEC_DIAG_EN
    ,
    .primer_fallo(primer_fallo1),
    .fallo_valido(fallo_valido1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sweep(input logic [7:0] esp, input logic [7:0] m,
                       input bit pulses, input int rst_at);
    int cyc;
    int busy_n;
    bit vec_ok;
    bit seen;
    logic [7:0] et;
    logic [8:0] ent;
    et = golden(m);
    sb_q.push_back({(et != esp), et});
    esperada = esp;
    fmask    = m;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1; busy_n = 0; vec_ok = 1; seen = 0;
    while (cyc < 200) begin
      if (busy) begin
        busy_n++;
        if (vec != 3'((busy_n - 1) / 10)) vec_ok = 0;
      end
      if (done) begin
        seen = 1;
        break;
      end
      if (rst_at != 0 && cyc == rst_at) break;
      start = pulses && (cyc == 5 || cyc == 40);
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    if (rst_at != 0) begin
      chk("tabla_pre_rst", 32'(tabla != 0), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_vec", 32'(vec), 32'd0);
      chk("rst_tabla", 32'(tabla), 32'd0);
      seen = 0;
      repeat (3) begin
        @(posedge clk);
        #1 if (done) seen = 1;
      end
      rst_n = 1'b1;
      repeat (90) begin
        @(posedge clk);
        #1 if (done) seen = 1;
      end
      chk("rst_no_done", 32'(seen), 32'd0);
      void'(sb_q.pop_front());
      return;
    end
    chk("done_lat", 32'(cyc), 32'd81);
    chk("busy_len", 32'(busy_n), 32'd80);
    chk("vec_seq", 32'(vec_ok), 32'd1);
    chk("done_seen", 32'(seen), 32'd1);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      ent = sb_q.pop_front();
      if (seen) begin
        chk("tabla", 32'(tabla), 32'(ent[7:0]));
        chk("error", 32'(error), 32'(ent[8]));
      end
    end
`ifdef GEN_VEC_DIAG_EN
    if (seen) begin
      chk("diag_valid", 32'(fallo_valido), 32'(ent[8]));
      if (ent[8]) begin
        int first;
        first = 0;
        for (int i = 7; i >= 0; i--) if (ent[i] != esp[i]) first = i;
        chk("diag_first", 32'(primer_fallo), 32'(first));
      end
    end
`endif
    @(posedge clk);
    #1;
    chk("done_once", 32'(done), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
    chk("error_hold", 32'(error), 32'(ent[8]));
  endtask

  initial begin
    int c;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    start1   = 1'b0;
    esperada = 8'hE8;
    fmask    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec0", 32'(vec), 32'd0);
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_done0", 32'(done), 32'd0);
    chk("rst_tabla0", 32'(tabla), 32'd0);
    chk("rst_error0", 32'(error), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    sweep(8'hE8, 8'h00, 0, 0);
    sweep(8'hE9, 8'h00, 0, 0);
    sweep(8'hE8, 8'h00, 1, 0);
    sweep(8'hE8, 8'h01, 0, 33);
    sweep(8'hE8, 8'h00, 0, 0);
    sweep(8'hE8, 8'h60, 0, 0);

    start1 = 1'b1;
    @(posedge clk);
    #1 c = 1;
    while (!done1 && c < 30) begin
      @(posedge clk);
      #1 c++;
    end
    chk("h1_done_lat", 32'(c), 32'd9);
    chk("h1_tabla", 32'(tabla1), 32'hE8);
    chk("h1_error", 32'(error1), 32'd0);
    chk("h1_idle_gap", 32'(busy1), 32'd0);
    @(posedge clk);
    #1;
    chk("h1_rebusy", 32'(busy1), 32'd1);
    chk("h1_vec0", 32'(vec1), 32'd0);
    @(posedge clk);
    #1;
    chk("h1_vec1", 32'(vec1), 32'd1);
    start1 = 1'b0;
    repeat (12) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
